multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles waiting on mem_ready before bus error, range 2..255.
REQ-002 Parameter STATE_W, default 4: state register width, >= 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 opcode  input  7; funct3  input  3; funct7_5  input  1; funct7_0  input  1: fields of the latched instruction register.
REQ-006 zero, srca31, srcb31, alur31  input  1 each: ALU flags from the compare subtraction.
REQ-007 mem_ready  input  1  memory completes the current request this cycle.
REQ-008 mdu_done  input  1  multiply/divide unit result valid (RV32M_EN only; otherwise ignored).
REQ-009 pc_write, ir_write, reg_write, mem_req, mem_we, adr_src  output  1 each: datapath strobes and selects.
REQ-010 alu_src_a, alu_src_b, result_src  output  2 each; imm_src  output  3; alu_control  output  4; load_store  output  3 (= funct3 during memory states, else 0).
REQ-011 mdu_start  output  1; illegal_instr, bus_error  output  1 each, sticky.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, MDU_WAIT, HALT.
REQ-013 FETCH: mem_req=1, adr_src=0 (PC); stays until mem_ready; on mem_ready: ir_write=1, pc_write=1 (PC+4), next DECODE.
REQ-014 DECODE, one cycle: opcode 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC; any other opcode -> HALT with illegal_instr set.
REQ-015 MEMADR: ALU computes rs1+imm; next MEMRD if opcode[5]=0, else MEMWR.
REQ-016 MEMRD/MEMWR: mem_req=1, adr_src=1, mem_we=1 only in MEMWR; hold until mem_ready; MEMRD -> MEMWB, MEMWR -> FETCH.
REQ-017 MEMWB, ALUWB, LUI, AUIPC, JAL, JALR: reg_write=1 exactly one cycle, next FETCH; JAL/JALR also pc_write=1 with target, rd receives old PC+4.
REQ-018 BRANCH: one cycle; lt=(srca31!=srcb31)?srca31:alur31; ltu=(srca31!=srcb31)?srcb31:alur31; funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; taken -> pc_write=1; funct3 010/011 -> HALT, illegal_instr.
REQ-019 alu_control: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001; SUB only for R-type funct7_5=1, funct3=000; SRA when funct3=101, funct7_5=1 (R and I); address/JAL/AUIPC use ADD; BRANCH uses SUB.
REQ-020 Wait counter: clears on entering any memory-wait state, increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> HALT, bus_error set, mem_req deasserted the next cycle.
REQ-021 mem_ready in a non-memory state is ignored; mem_ready and timeout in same cycle -> mem_ready wins.
REQ-022 HALT: all strobes 0; exit only by reset.
REQ-023 Strobes (pc_write, ir_write, reg_write, mem_we) are Moore outputs except FETCH ir_write/pc_write and BRANCH pc_write, gated combinationally by mem_ready/branch result.

Reset
REQ-024 rst_n low: state=FETCH, counter=0, illegal_instr=0, bus_error=0 immediately, independent of clk.
REQ-025 Reset mid-transaction aborts it; mem_req drops asynchronously; first FETCH request the cycle after rst_n deasserts.

Configuration
REQ-026 RV32M_EN defined: opcode 0110011 with funct7_0=1 goes EXEC_R -> MDU_WAIT with mdu_start=1 one cycle; MDU_WAIT holds until mdu_done, then ALUWB with result_src=11.
REQ-027 RV32M_EN undefined: funct7_0=1 on opcode 0110011 -> HALT, illegal_instr; mdu_start tied 0; MDU_WAIT unreachable.

Verification
REQ-028 add x3,x1,x2 (0110011, f3 000, f7_5=0), mem_ready=1 always -> FETCH,DECODE,EXEC_R,ALUWB: 4 cycles, one reg_write, alu_control=0000.
REQ-029 lw, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_req=1, load_store=010, then MEMWB reg_write=1.
REQ-030 blt with srca31=1, srcb31=0 -> pc_write=1 in BRANCH; bgeu same flags -> pc_write=0.
REQ-031 mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> bus_error=1 after 4 wait cycles, HALT, mem_req=0 thereafter until reset.
REQ-032 opcode 0000000 -> illegal_instr=1, HALT; rst_n pulse low mid-HALT -> flags clear, FETCH with mem_req=1.
REQ-033 RV32M_EN: mul (f7_0=1), mdu_done after 5 cycles -> mdu_start one pulse, MDU_WAIT 5 cycles, reg_write once; without macro -> illegal_instr=1.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/datapath bundle for multicycle_controller
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       funct7_0;
  logic       zero;
  logic       srca31;
  logic       srcb31;
  logic       alur31;
  logic       mem_ready;
  logic       mdu_done;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic [2:0] load_store;
  logic       mdu_start;
  logic       illegal_instr;
  logic       bus_error;

  modport master (
    input  opcode, funct3, funct7_5, funct7_0, zero, srca31, srcb31, alur31,
           mem_ready, mdu_done,
    output pc_write, ir_write, reg_write, mem_req, mem_we, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control, load_store,
           mdu_start, illegal_instr, bus_error
  );

  modport slave (
    output opcode, funct3, funct7_5, funct7_0, zero, srca31, srcb31, alur31,
           mem_ready, mdu_done,
    input  pc_write, ir_write, reg_write, mem_req, mem_we, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control, load_store,
           mdu_start, illegal_instr, bus_error
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM; M-extension enabled by RV32M_EN
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

`ifdef RV32M_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0),  S_DECODE = STATE_W'(1),
                                 S_MEMADR = STATE_W'(2),  S_MEMRD  = STATE_W'(3),
                                 S_MEMWB  = STATE_W'(4),  S_MEMWR  = STATE_W'(5),
                                 S_EXEC_R = STATE_W'(6),  S_EXEC_I = STATE_W'(7),
                                 S_ALUWB  = STATE_W'(8),  S_BRANCH = STATE_W'(9),
                                 S_JAL    = STATE_W'(10), S_JALR   = STATE_W'(11),
                                 S_LUI    = STATE_W'(12), S_AUIPC  = STATE_W'(13),
                                 S_MDU    = STATE_W'(14), S_HALT   = STATE_W'(15);

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [STATE_W-1:0] r_state, w_next;
  logic [7:0]         r_wait;
  logic               r_illegal, r_bus_err, r_mdu;
  logic               w_lt, w_ltu, w_taken, w_br_ok, w_mem_wait;
  logic               w_set_ill, w_set_berr;
  logic [3:0]         w_alu_fn;

  assign w_lt       = (bus.srca31 != bus.srcb31) ? bus.srca31 : bus.alur31;
  assign w_ltu      = (bus.srca31 != bus.srcb31) ? bus.srcb31 : bus.alur31;
  assign w_br_ok    = (bus.funct3[2:1] != 2'b01);
  assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  always_comb begin
    w_taken = 1'b0;
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = !bus.zero;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // opcode[5] separates R-type (SUB possible) from I-type (addi never subtracts)
  always_comb begin
    w_alu_fn = ALU_ADD;
    case (bus.funct3)
      3'b000: w_alu_fn = (bus.opcode[5] && bus.funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_fn = ALU_SLL;
      3'b010: w_alu_fn = ALU_SLT;
      3'b011: w_alu_fn = ALU_SLTU;
      3'b100: w_alu_fn = ALU_XOR;
      3'b101: w_alu_fn = bus.funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_fn = ALU_OR;
      3'b111: w_alu_fn = ALU_AND;
      default: w_alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_set_ill  = 1'b0;
    w_set_berr = 1'b0;
    case (r_state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (bus.mem_ready)
          w_next = (r_state == S_FETCH) ? S_DECODE : (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (r_wait == TO_LAST) begin
          w_next     = S_HALT;
          w_set_berr = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011: begin
            w_next    = (bus.funct7_0 && !MDU_EN) ? S_HALT : S_EXEC_R;
            w_set_ill = bus.funct7_0 && !MDU_EN;
          end
          7'b0010011: w_next = S_EXEC_I;
          7'b1100011: w_next = S_BRANCH;
          7'b1101111: w_next = S_JAL;
          7'b1100111: w_next = S_JALR;
          7'b0110111: w_next = S_LUI;
          7'b0010111: w_next = S_AUIPC;
          default: begin
            w_next    = S_HALT;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = bus.opcode[5] ? S_MEMWR : S_MEMRD;
      S_EXEC_R: w_next = (MDU_EN && bus.funct7_0) ? S_MDU : S_ALUWB;
      S_EXEC_I: w_next = S_ALUWB;
      S_MDU:    w_next = bus.mdu_done ? S_ALUWB : S_MDU;
      S_BRANCH: begin
        w_next    = w_br_ok ? S_FETCH : S_HALT;
        w_set_ill = !w_br_ok;
      end
      S_MEMWB, S_ALUWB, S_JAL, S_JALR, S_LUI, S_AUIPC: w_next = S_FETCH;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_mdu     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_mem_wait)
        r_wait <= 8'd0;
      else if (!bus.mem_ready)
        r_wait <= r_wait + 8'd1;
      if (w_set_ill)  r_illegal <= 1'b1;
      if (w_set_berr) r_bus_err <= 1'b1;
      if (w_next == S_MDU)         r_mdu <= 1'b1;
      else if (r_state == S_FETCH) r_mdu <= 1'b0;
    end
  end

  assign bus.illegal_instr = r_illegal;
  assign bus.bus_error     = r_bus_err;

  // rst_n gates every strobe so an in-flight request drops without waiting for a clock
  always_comb begin
    bus.pc_write    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.adr_src     = 1'b0;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.result_src  = 2'b00;
    bus.alu_control = ALU_ADD;
    bus.load_store  = 3'b000;
    bus.mdu_start   = 1'b0;
    bus.imm_src     = 3'b000;
    case (bus.opcode)
      7'b0100011:             bus.imm_src = 3'b001;
      7'b1100011:             bus.imm_src = 3'b010;
      7'b0110111, 7'b0010111: bus.imm_src = 3'b011;
      7'b1101111:             bus.imm_src = 3'b100;
      default:                bus.imm_src = 3'b000;
    endcase
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        S_MEMRD, S_MEMWR: begin
          bus.mem_req    = 1'b1;
          bus.adr_src    = 1'b1;
          bus.mem_we     = (r_state == S_MEMWR);
          bus.load_store = bus.funct3;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b01;
          bus.load_store = bus.funct3;
        end
        S_EXEC_R, S_EXEC_I: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = (r_state == S_EXEC_I) ? 2'b01 : 2'b00;
          bus.alu_control = w_alu_fn;
          bus.mdu_start   = MDU_EN && (r_state == S_EXEC_R) && bus.funct7_0;
        end
        S_ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = r_mdu ? 2'b11 : 2'b00;
        end
        S_BRANCH: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_control = ALU_SUB;
          bus.pc_write    = w_taken;
        end
        // jump target sits in ALUOut from DECODE/JALR; ALU forms old PC+4 for rd
        S_JAL, S_JALR: begin
          bus.alu_src_a = (r_state == S_JAL) ? 2'b01 : 2'b10;
          bus.alu_src_b = (r_state == S_JAL) ? 2'b10 : 2'b01;
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
        end
        S_LUI, S_AUIPC: begin
          bus.alu_src_a  = (r_state == S_LUI) ? 2'b11 : 2'b01;
          bus.alu_src_b  = 2'b01;
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bif ();
  multicycle_controller #(.MEM_TIMEOUT(4), .STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

`ifdef RV32M_EN
  localparam int MUL_CYC = 5, MUL_REGW = 1, MUL_ILL = 0;
`else
  localparam int MUL_CYC = 0, MUL_REGW = 0, MUL_ILL = 1;
`endif

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic       f70;
    logic [3:0] flg;   // {zero, srca31, srcb31, alur31}
    int         cyc;   // cycles until next fetch strobe, 0 = halts
    int         regw;
    int         pcw;
    logic [3:0] alu;   // alu_control in the third cycle
    logic       ill;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic f70, input logic [3:0] flg);
    bif.opcode = op; bif.funct3 = f3; bif.funct7_5 = f75; bif.funct7_0 = f70;
    {bif.zero, bif.srca31, bif.srcb31, bif.alur31} = flg;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, regw, pcw;
    logic [3:0] alu;
    cyc = 0; regw = 0; pcw = 0; alu = 4'hf;
    set_instr(v.op, v.f3, v.f75, v.f70, v.flg);
    bif.mem_ready = 1'b1;
    bif.mdu_done  = 1'b1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k > 0 && bif.ir_write === 1'b1) begin
        cyc = k;
        break;
      end
      if (k > 0) begin
        regw += int'(bif.reg_write);
        pcw  += int'(bif.pc_write);
      end
      if (k == 2) alu = bif.alu_control;
      @(negedge clk);
    end
    chk({v.name, " cycles"}, cyc, v.cyc);
    chk({v.name, " reg_write"}, regw, v.regw);
    chk({v.name, " pc_write"}, pcw, v.pcw);
    chk({v.name, " alu_control"}, alu, v.alu);
    chk({v.name, " illegal_instr"}, bif.illegal_instr, v.ill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, cnt2, kw;
    logic [2:0] ls;
    logic [1:0] rs;
    rst_n = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4'b0000);
    bif.mem_ready = 1'b0;
    bif.mdu_done  = 1'b0;

    vq.push_back('{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4'b0000, 4, 1, 0, 4'b0000, 1'b0});
    vq.push_back('{"sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4'b0000, 4, 1, 0, 4'b0001, 1'b0});
    vq.push_back('{"sra",   7'b0110011, 3'b101, 1'b1, 1'b0, 4'b0000, 4, 1, 0, 4'b1001, 1'b0});
    vq.push_back('{"sltu",  7'b0110011, 3'b011, 1'b0, 1'b0, 4'b0000, 4, 1, 0, 4'b0110, 1'b0});
    vq.push_back('{"addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 4'b0000, 4, 1, 0, 4'b0000, 1'b0});
    vq.push_back('{"srai",  7'b0010011, 3'b101, 1'b1, 1'b0, 4'b0000, 4, 1, 0, 4'b1001, 1'b0});
    vq.push_back('{"andi",  7'b0010011, 3'b111, 1'b0, 1'b0, 4'b0000, 4, 1, 0, 4'b0010, 1'b0});
    vq.push_back('{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 4'b0000, 5, 1, 0, 4'b0000, 1'b0});
    vq.push_back('{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4'b0000, 4, 0, 0, 4'b0000, 1'b0});
    vq.push_back('{"beq",   7'b1100011, 3'b000, 1'b0, 1'b0, 4'b1000, 3, 0, 1, 4'b0001, 1'b0});
    vq.push_back('{"bne",   7'b1100011, 3'b001, 1'b0, 1'b0, 4'b1000, 3, 0, 0, 4'b0001, 1'b0});
    vq.push_back('{"blt",   7'b1100011, 3'b100, 1'b0, 1'b0, 4'b0100, 3, 0, 1, 4'b0001, 1'b0});
    vq.push_back('{"bltu",  7'b1100011, 3'b110, 1'b0, 1'b0, 4'b0100, 3, 0, 0, 4'b0001, 1'b0});
    vq.push_back('{"bge",   7'b1100011, 3'b101, 1'b0, 1'b0, 4'b0000, 3, 0, 1, 4'b0001, 1'b0});
    vq.push_back('{"bgeu",  7'b1100011, 3'b111, 1'b0, 1'b0, 4'b0001, 3, 0, 0, 4'b0001, 1'b0});
    vq.push_back('{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4'b0000, 3, 1, 1, 4'b0000, 1'b0});
    vq.push_back('{"jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 4'b0000, 3, 1, 1, 4'b0000, 1'b0});
    vq.push_back('{"lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 4'b0000, 3, 1, 0, 4'b0000, 1'b0});
    vq.push_back('{"auipc", 7'b0010111, 3'b000, 1'b0, 1'b0, 4'b0000, 3, 1, 0, 4'b0000, 1'b0});
    vq.push_back('{"bad_br",7'b1100011, 3'b010, 1'b0, 1'b0, 4'b1000, 0, 0, 0, 4'b0001, 1'b1});
    vq.push_back('{"mul",   7'b0110011, 3'b000, 1'b0, 1'b1, 4'b0000, MUL_CYC, MUL_REGW, 0, 4'b0000, 1'(MUL_ILL)});
    vq.push_back('{"op0",   7'b0000000, 3'b000, 1'b0, 1'b0, 4'b0000, 0, 0, 0, 4'b0000, 1'b1});

    // reset state, asserted with no clock edge in between
    @(posedge clk);
    #2;
    chk("reset mem_req", bif.mem_req, 1'b0);
    chk("reset illegal_instr", bif.illegal_instr, 1'b0);
    chk("reset bus_error", bif.bus_error, 1'b0);

    foreach (vq[i]) run_vec(vq[i]);

    // still halted after op0: async reset clears the sticky flag, fetch resumes
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("halt reset illegal_instr", bif.illegal_instr, 1'b0);
    chk("halt reset mem_req", bif.mem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post reset mem_req", bif.mem_req, 1'b1);
    chk("post reset adr_src", bif.adr_src, 1'b0);

    // lw: fetch waits 3 cycles, then MEMRD waits 3 cycles (counter must restart)
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 4'b0000);
    bif.mem_ready = 1'b0;
    do_reset();
    cnt = 0; cnt2 = 0; kw = -1; ls = 3'b000;
    for (int k = 0; k <= 10; k++) begin
      bif.mem_ready = !(k inside {0, 1, 2, 6, 7, 8});
      #1;
      if (bif.mem_req === 1'b1 && bif.adr_src === 1'b1) cnt++;
      cnt2 += int'(bif.mem_we);
      if (k == 6) ls = bif.load_store;
      if (bif.reg_write === 1'b1 && kw < 0) kw = k;
      @(negedge clk);
    end
    chk("lw memrd cycles", cnt, 4);
    chk("lw mem_we count", cnt2, 0);
    chk("lw load_store", ls, 3'b010);
    chk("lw reg_write cycle", kw, 10);
    chk("lw bus_error", bif.bus_error, 1'b0);

    // mid-transaction reset drops mem_req asynchronously
    bif.mem_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bif.mem_ready = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("memrd mem_req", bif.mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort mem_req", bif.mem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort refetch adr_src", {bif.mem_req, bif.adr_src}, 2'b10);

    // fetch timeout with MEM_TIMEOUT=4
    bif.mem_ready = 1'b0;
    do_reset();
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      cnt += int'(bif.mem_req);
      if (k == 3) chk("timeout bus_error early", bif.bus_error, 1'b0);
      @(negedge clk);
    end
    chk("timeout wait req cycles", cnt, 4);
    #1;
    chk("timeout bus_error", bif.bus_error, 1'b1);
    chk("timeout mem_req", bif.mem_req, 1'b0);
    bif.mem_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      cnt += int'(bif.mem_req) + int'(bif.ir_write) + int'(bif.pc_write);
    end
    chk("halt strobes", cnt, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("halt reset bus_error", bif.bus_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // mul with mdu_done arriving on the fifth wait cycle
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b1, 4'b0000);
    bif.mem_ready = 1'b1;
    bif.mdu_done  = 1'b0;
    do_reset();
    cnt = 0; cnt2 = 0; kw = -1; rs = 2'b00;
    for (int k = 0; k <= 8; k++) begin
      bif.mdu_done = (k == 7);
      #1;
      cnt  += int'(bif.mdu_start);
      cnt2 += int'(bif.reg_write);
      if (bif.reg_write === 1'b1 && kw < 0) begin
        kw = k;
        rs = bif.result_src;
      end
      @(negedge clk);
    end
`ifdef RV32M_EN
    chk("mul mdu_start pulses", cnt, 1);
    chk("mul reg_write count", cnt2, 1);
    chk("mul reg_write cycle", kw, 8);
    chk("mul result_src", rs, 2'b11);
    chk("mul illegal_instr", bif.illegal_instr, 1'b0);
`else
    chk("mul mdu_start pulses", cnt, 0);
    chk("mul reg_write count", cnt2, 0);
    chk("mul illegal_instr", bif.illegal_instr, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
